// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store initiator.
//   SZ_*    : request size field encodings (2 bits)
//   state_t : sequencing FSM states of mem_access_unit
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ISSUE = 3'd1,
    ST_RD_WAIT  = 3'd2,
    ST_WR_ISSUE = 3'd3,
    ST_RESP     = 3'd4
  } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic for a 32-bit little-endian word memory.
//   size       in  2   request size (byte/half/word/reserved)
//   sign       in  1   sign-extend sub-word load result
//   addr_lo    in  2   byte offset within the word
//   rword      in  32  word read from memory
//   wdata      in  32  store data, right-justified for byte/half
//   misaligned out 1   size/offset combination not allowed (reserved size included)
//   load_data  out 32  extracted and extended load result
//   merged     out 32  rword with the store lane(s) replaced by wdata
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic        misaligned,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [31:0] lane_mask;
  logic [31:0] lane_data;

  // For aligned halves addr_lo[0]=0, so one byte-granular shift serves all sizes.
  assign shamt   = {addr_lo, 3'b000};
  assign shifted = rword >> shamt;

  always_comb begin
    misaligned = 1'b0;
    load_data  = '0;
    lane_mask  = '0;
    lane_data  = '0;
    merged     = rword;
    case (size)
      SZ_BYTE: begin
        load_data = sign ? {{24{shifted[7]}}, shifted[7:0]} : {24'h0, shifted[7:0]};
        lane_mask = 32'h0000_00ff << shamt;
        lane_data = {24'h0, wdata[7:0]} << shamt;
        merged    = (rword & ~lane_mask) | lane_data;
      end
      SZ_HALF: begin
        misaligned = addr_lo[0];
        load_data  = sign ? {{16{shifted[15]}}, shifted[15:0]} : {16'h0, shifted[15:0]};
        lane_mask  = 32'h0000_ffff << shamt;
        lane_data  = {16'h0, wdata[15:0]} << shamt;
        merged     = (rword & ~lane_mask) | lane_data;
      end
      SZ_WORD: begin
        misaligned = |addr_lo;
        load_data  = rword;
        merged     = wdata;
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator between the multicycle datapath and the word-addressed
// data memory. Byte/half stores are done as read-modify-write.
//   clk, reset         clock; asynchronous active-high reset
//   req_*              CPU request (valid/ready handshake, write, size, signed, addr, wdata)
//   resp_*             one-cycle completion pulse with load data and error flag
//   mem_*              memory strobes, word index, write word and registered read data
//
// state       | meaning
// ST_IDLE     | ready for a request; misaligned requests go straight to ST_RESP
// ST_RD_ISSUE | memread strobe for a load or the read half of a read-modify-write
// ST_RD_WAIT  | mem_data valid; capture load result or merged store word
// ST_WR_ISSUE | memwrite strobe with full or merged word
// ST_RESP     | resp_valid pulse, then back to ST_IDLE
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writeData,
  output logic              mem_memread,
  output logic              mem_memwrite,
  input  logic [DATA_W-1:0] mem_data
);

  state_t state, state_nxt;

  logic              accept;
  logic              write_q;
  logic [1:0]        size_q;
  logic              sign_q;
  logic [1:0]        addr_lo_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic [1:0]        al_size;
  logic [1:0]        al_addr_lo;
  logic              misaligned;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merged;

  // In IDLE the lane logic sees the live request so the misalign decision is
  // available at the accept edge; afterwards it works on the latched request.
  assign al_size    = (state == ST_IDLE) ? req_size      : size_q;
  assign al_addr_lo = (state == ST_IDLE) ? req_addr[1:0] : addr_lo_q;

  mem_lane_align u_align (
    .size       (al_size),
    .sign       (sign_q),
    .addr_lo    (al_addr_lo),
    .rword      (mem_data),
    .wdata      (wdata_q),
    .misaligned (misaligned),
    .load_data  (load_data),
    .merged     (merged)
  );

  assign accept     = req_valid & req_ready;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    mem_memread  = 1'b0;
    mem_memwrite = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (misaligned)                           state_nxt = ST_RESP;
          else if (!req_write || req_size != SZ_WORD) state_nxt = ST_RD_ISSUE;
          else                                      state_nxt = ST_WR_ISSUE;
        end
      end
      ST_RD_ISSUE: begin
        mem_memread = 1'b1;
        state_nxt   = ST_RD_WAIT;
      end
      ST_RD_WAIT:  state_nxt = write_q ? ST_WR_ISSUE : ST_RESP;
      ST_WR_ISSUE: begin
        mem_memwrite = 1'b1;
        state_nxt    = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_q       <= 1'b0;
      size_q        <= SZ_BYTE;
      sign_q        <= 1'b0;
      addr_lo_q     <= 2'b00;
      wdata_q       <= '0;
      rdata_q       <= '0;
      err_q         <= 1'b0;
      mem_address   <= '0;
      mem_writeData <= '0;
    end else begin
      if (accept) begin
        write_q     <= req_write;
        size_q      <= req_size;
        sign_q      <= req_signed;
        addr_lo_q   <= req_addr[1:0];
        wdata_q     <= req_wdata;
        rdata_q     <= '0;
        err_q       <= misaligned;
        mem_address <= {2'b00, req_addr[ADDR_W-1:2]};
        if (req_write && req_size == SZ_WORD && !misaligned)
          mem_writeData <= req_wdata;
      end
      if (state == ST_RD_WAIT) begin
        if (write_q) mem_writeData <= merged;
        else         rdata_q       <= load_data;
      end
      // Response fields are only non-zero while resp_valid is high.
      if (state == ST_RESP) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end

endmodule
